// File: rtl/fifo_uart_tx_if.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx_if
// Read-side connection between a byte FIFO and the fifo_uart_tx serialiser.
//   fifo_ren   : one-cycle read pulse issued by the transmitter
//   fifo_rdata : registered head byte presented by the FIFO
//   fifo_count : FIFO occupancy (AWIDTH+1 bits)
// Modports: master = transmitter side, slave = FIFO side.
// -----------------------------------------------------------------------------
interface fifo_uart_tx_if #(
   parameter int AWIDTH = 8
);
   logic              fifo_ren;
   logic [7:0]        fifo_rdata;
   logic [AWIDTH:0]   fifo_count;

   modport master (output fifo_ren, input fifo_rdata, input fifo_count);
   modport slave  (input fifo_ren, output fifo_rdata, output fifo_count);
endinterface

// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
// Drains a byte FIFO and shifts each byte out as an asynchronous UART frame:
// start bit, 8 data bits LSB first, optional even parity, one stop bit.
//
// Ports:
//   clk      : single clock, rising edge
//   rst      : asynchronous reset, active-low
//   en       : start permission, sampled only while idle
//   fifo     : fifo_uart_tx_if.master (fifo_ren out, fifo_rdata/fifo_count in)
//   tx       : registered serial line, idle high
//   busy     : high whenever a frame is being fetched or sent
//   tx_done  : one-cycle pulse in the last cycle of the stop bit
//
// Build option: define FIFO_UART_TX_PARITY_EN to add an even-parity bit
// (11-bit frames). Without it frames are 10 bits. Ports are identical.
// -----------------------------------------------------------------------------
module fifo_uart_tx #(
   parameter int MAX_DATA     = 256,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   fifo_uart_tx_if.master fifo,
   output logic           tx,
   output logic           busy,
   output logic           tx_done
);

   localparam int AWIDTH = $clog2(MAX_DATA);
   localparam int CW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0]   BAUD_LAST   = CW'(CLKS_PER_BIT - 1);
   localparam logic [AWIDTH:0] COUNT_EMPTY = '0;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_LOAD   = 3'd2;
   localparam logic [2:0] S_START  = 3'd3;
   localparam logic [2:0] S_DATA   = 3'd4;
`ifdef FIFO_UART_TX_PARITY_EN
   localparam logic [2:0] S_PARITY = 3'd5;
`endif
   localparam logic [2:0] S_STOP   = 3'd6;

   logic [2:0]    state_q, state_d;
   logic          tx_q, tx_d;
   logic [CW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          baud_end;
`ifdef FIFO_UART_TX_PARITY_EN
   logic          parity_q, parity_d;
`endif

   assign baud_end = (baud_q == BAUD_LAST);

   always_comb begin
      state_d = state_q;
      tx_d    = tx_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_d = parity_q;
`endif
      case (state_q)
         S_IDLE: begin
            tx_d = 1'b1;
            // Only the occupancy count gates the start; a byte written on the
            // edge that makes count non-zero is registered by the time we read.
            if (en && (fifo.fifo_count != COUNT_EMPTY)) state_d = S_FETCH;
         end
         S_FETCH: state_d = S_LOAD;
         S_LOAD: begin
            // FIFO registered the head byte at the FETCH edge.
            shift_d = fifo.fifo_rdata;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_d = ^fifo.fifo_rdata;
`endif
            tx_d    = 1'b0;
            baud_d  = '0;
            state_d = S_START;
         end
         S_START: begin
            if (baud_end) begin
               baud_d  = '0;
               bit_d   = 3'd0;
               tx_d    = shift_q[0];
               state_d = S_DATA;
            end else begin
               baud_d = baud_q + CW'(1);
            end
         end
         S_DATA: begin
            if (baud_end) begin
               baud_d = '0;
               if (bit_q == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
                  tx_d    = parity_q;
                  state_d = S_PARITY;
`else
                  tx_d    = 1'b1;
                  state_d = S_STOP;
`endif
               end else begin
                  // Shift right so the next bit to send is always in bit 1.
                  bit_d   = bit_q + 3'd1;
                  shift_d = shift_q >> 1;
                  tx_d    = shift_q[1];
               end
            end else begin
               baud_d = baud_q + CW'(1);
            end
         end
`ifdef FIFO_UART_TX_PARITY_EN
         S_PARITY: begin
            if (baud_end) begin
               baud_d  = '0;
               tx_d    = 1'b1;
               state_d = S_STOP;
            end else begin
               baud_d = baud_q + CW'(1);
            end
         end
`endif
         S_STOP: begin
            if (baud_end) begin
               baud_d  = '0;
               state_d = S_IDLE;
            end else begin
               baud_d = baud_q + CW'(1);
            end
         end
         default: begin
            tx_d    = 1'b1;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         tx_q    <= 1'b1;
         baud_q  <= '0;
         bit_q   <= 3'd0;
         shift_q <= 8'h00;
`ifdef FIFO_UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         tx_q    <= tx_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
`ifdef FIFO_UART_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   // Outputs other than tx are pure decodes of registered state.
   assign tx            = tx_q;
   assign busy          = (state_q != S_IDLE);
   assign fifo.fifo_ren = (state_q == S_FETCH);
   assign tx_done       = (state_q == S_STOP) && baud_end;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_fifo_uart_tx
// Drives fifo_uart_tx from a queue-based FIFO model. Bytes written to the FIFO
// are pushed to an expected-byte queue; a negedge monitor decodes each frame
// on tx and compares it bit-by-bit against a frame built from the byte.
// -----------------------------------------------------------------------------
module tb_fifo_uart_tx;
   localparam int MAX_DATA = 16;
   localparam int AW       = $clog2(MAX_DATA);
   localparam int C        = 4;
`ifdef FIFO_UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif

   logic clk = 1'b0;
   logic rst;
   logic en;
   logic tx, busy, tx_done;

   fifo_uart_tx_if #(.AWIDTH(AW)) bus ();

   fifo_uart_tx #(.MAX_DATA(MAX_DATA), .CLKS_PER_BIT(C)) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .fifo    (bus),
      .tx      (tx),
      .busy    (busy),
      .tx_done (tx_done)
   );

   always #5 clk = ~clk;

   // FIFO model: registered read data, count updated at the edge.
   logic [7:0] fq[$];
   logic       wr_en   = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       ren_s   = 1'b0;
   logic [AW:0] cnt_r  = '0;
   logic [7:0]  rdata_r = 8'h00;
   int underflow = 0;

   assign bus.fifo_count = cnt_r;
   assign bus.fifo_rdata = rdata_r;

   always @(posedge clk) begin
      if (wr_en) fq.push_back(wr_data);
      if (ren_s) begin
         if (fq.size() == 0) underflow++;
         else rdata_r <= fq.pop_front();
      end
      cnt_r <= (AW+1)'(fq.size());
   end

   // Scoreboard state
   logic [7:0] exp_q[$];
   int start_q[$];
   int cyc = 0, checks = 0, errors = 0;
   int ren_cnt = 0, starts = 0, frames_done = 0, idle_bad = 0, pos = 0;
   int first_nz_cyc = -1;
   logic [AW:0] prev_cnt = '0;
   bit in_frame = 1'b0, frame_bad = 1'b0;
   logic [NB-1:0] fbits = '1;
   logic [7:0] cur = 8'h00;

   function automatic logic [NB-1:0] make_frame(input logic [7:0] b);
      logic [NB-1:0] f;
      int ones;
      f    = '1;
      f[0] = 1'b0;
      ones = 0;
      for (int i = 0; i < 8; i++) begin
         f[1+i] = b[i];
         ones += int'(b[i]);
      end
`ifdef FIFO_UART_TX_PARITY_EN
      f[9] = ((ones % 2) == 1);
`endif
      return f;
   endfunction

   // Monitor
   always @(negedge clk) begin
      cyc++;
      ren_s = bus.fifo_ren;
      if (cnt_r != 0 && prev_cnt == 0) first_nz_cyc = cyc;
      prev_cnt = cnt_r;
      if (rst !== 1'b1) begin
         in_frame = 1'b0;
         pos = 0;
         if (tx !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0 || bus.fifo_ren !== 1'b0) idle_bad++;
      end else begin
         if (bus.fifo_ren === 1'b1) ren_cnt++;
         if (!in_frame && tx === 1'b0) begin
            in_frame  = 1'b1;
            pos       = 0;
            frame_bad = 1'b0;
            starts++;
            start_q.push_back(cyc);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_frame actual=frame_start required=no_frame cyc=%0d", cyc);
               cur = 8'h00;
            end else begin
               cur = exp_q.pop_front();
            end
            fbits = make_frame(cur);
         end
         if (in_frame) begin
            pos++;
            if (tx !== fbits[(pos-1)/C]) frame_bad = 1'b1;
            if (tx_done !== (pos == NB*C)) frame_bad = 1'b1;
            if (busy !== 1'b1) frame_bad = 1'b1;
            if (pos == NB*C) begin
               checks++;
               if (frame_bad) begin
                  errors++;
                  $display("FAIL frame actual=bad_bits_or_timing required=byte_%02h bits=%b", cur, fbits);
               end
               frames_done++;
               in_frame = 1'b0;
            end
         end else if (tx !== 1'b1 || tx_done !== 1'b0) begin
            idle_bad++;
         end
      end
   end

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic push(input logic [7:0] b);
      @(negedge clk);
      wr_en   = 1'b1;
      wr_data = b;
      exp_q.push_back(b);
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_idle(input string name);
      int k;
      k = 0;
      while (k < 4000 && (in_frame || fq.size() != 0 || busy !== 1'b0)) begin
         @(negedge clk);
         k++;
      end
      check({name, "_timeout"}, int'(k < 4000), 1);
      wait_cycles(5);
   endtask

   int r0, s0, d0, q0, k;
   logic [3:0] o4;
   logic [2:0] o3;

   initial begin
      rst = 1'b0;
      en  = 1'b0;

      // Reset held for 5 cycles
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         o4 = {tx, busy, bus.fifo_ren, tx_done};
         check("reset_outputs", int'(o4), 4'b1000);
      end
      @(negedge clk);
      rst = 1'b1;
      en  = 1'b1;
      wait_cycles(10);
      check("post_reset_starts", starts, 0);
      check("post_reset_ren", ren_cnt, 0);
      check("post_reset_busy", int'(busy), 0);

      // Single byte
      r0 = ren_cnt; d0 = frames_done;
      push(8'hA5);
      wait_idle("single");
      check("single_ren", ren_cnt - r0, 1);
      check("single_frames", frames_done - d0, 1);

      // Back-to-back from a preloaded FIFO
      en = 1'b0;
      push(8'h00); push(8'hFF); push(8'h3C);
      wait_cycles(2);
      check("b2b_preload_count", int'(cnt_r), 3);
      r0 = ren_cnt; q0 = start_q.size();
      en = 1'b1;
      wait_idle("b2b");
      check("b2b_ren", ren_cnt - r0, 3);
      check("b2b_count_end", int'(cnt_r), 0);
      check("b2b_starts", start_q.size() - q0, 3);
      if (start_q.size() >= q0 + 3) begin
         check("b2b_period_1", start_q[q0+1] - start_q[q0], NB*C + 3);
         check("b2b_period_2", start_q[q0+2] - start_q[q0+1], NB*C + 3);
      end

      // en gating
      en = 1'b0;
      push(8'h11); push(8'h22);
      r0 = ren_cnt; s0 = starts;
      wait_cycles(50);
      check("gate_ren", ren_cnt - r0, 0);
      check("gate_starts", starts - s0, 0);
      check("gate_tx_idle", int'(tx), 1);
      r0 = ren_cnt; d0 = frames_done;
      en = 1'b1;
      k = 0;
      while (!in_frame && k < 20) begin @(negedge clk); k++; end
      check("gate_frame_started", int'(in_frame), 1);
      en = 1'b0;
      wait_cycles(NB*C + 40);
      check("gate_mid_frame_ren", ren_cnt - r0, 1);
      check("gate_mid_frame_frames", frames_done - d0, 1);
      check("gate_busy_after", int'(busy), 0);
      check("gate_count_left", int'(cnt_r), 1);
      en = 1'b1;
      wait_idle("gate_drain");

      // Reset during data bit 4
      push(8'hC3);
      k = 0;
      while (!(in_frame && pos >= 5*C + 2 && pos <= 6*C - 1) && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("rst_mid_reached", int'(k < 200), 1);
      #2 rst = 1'b0;
      #1 o3 = {tx, bus.fifo_ren, busy};
      check("rst_mid_async", int'(o3), 3'b100);
      wait_cycles(3);
      rst = 1'b1;
      r0 = ren_cnt; s0 = starts;
      wait_cycles(30);
      check("rst_mid_no_restart", starts - s0, 0);
      check("rst_mid_no_ren", ren_cnt - r0, 0);

      // Write into an empty FIFO while idle
      q0 = start_q.size(); d0 = frames_done;
      push(8'h5A);
      wait_idle("empty_write");
      check("empty_write_frames", frames_done - d0, 1);
      if (start_q.size() > q0)
         check("empty_write_latency", start_q[q0] - first_nz_cyc, 3);

      // Randomized traffic
      for (int it = 0; it < 12; it++) begin
         int n;
         n  = int'($urandom_range(1, 3));
         en = ($urandom_range(0, 3) != 0);
         for (int j = 0; j < n; j++)
            if (fq.size() < MAX_DATA - 3) push(8'($urandom_range(0, 255)));
         wait_cycles(int'($urandom_range(0, 60)));
      end
      en = 1'b1;
      wait_idle("random");
      check("random_drained", exp_q.size(), 0);
      check("ren_equals_starts", ren_cnt, starts);
      check("idle_line_clean", idle_bad, 0);
      check("no_underflow", underflow, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Serial transmit stage that drains the byte FIFO directly downstream of it. It watches the FIFO occupancy count and issues one-cycle read pulses. It captures the FIFO's registered read data and shifts each byte out as an asynchronous UART frame: start bit, 8 data bits LSB first, optional even parity, then 1 stop bit. It is the consumer half of the byte path: the FIFO's `ren`, `rdata` and `count` connect here, and `tx` goes to the pad.

## Interface
- `MAX_DATA`, default 256. FIFO depth; must match the FIFO instance. Sets `AWIDTH = $clog2(MAX_DATA)`.
- `CLKS_PER_BIT`, default 16. Clock cycles per serial bit; legal range ≥ 2. The baud counter is `$clog2(CLKS_PER_BIT)` bits wide.
- `clk`  in  1  Single clock. All state changes on the rising edge.
- `rst`  in  1  Reset, asynchronous assert, active-low (0 = reset).
- `en`  in  1  Start permission. Sampled only in IDLE; a frame in progress always completes.
- `fifo_count`  in  AWIDTH+1  FIFO occupancy.
- `fifo_rdata`  in  8  FIFO registered read data.
- `fifo_ren`  out  1  FIFO read pulse: exactly one cycle per frame.
- `tx`  out  1  Serial line, registered, idle high.
- `busy`  out  1  High in every state except IDLE.
- `tx_done`  out  1  One-cycle pulse in the last cycle of the stop bit.

## Operation
- **Reset values:** state = IDLE, `tx` = 1, `fifo_ren` = 0, `busy` = 0, `tx_done` = 0, baud counter = 0, bit index = 0, shift register = 0.
- **IDLE:** if `en` && `fifo_count` != 0, go to FETCH. Otherwise stay. `tx` = 1.
- **FETCH:** one cycle. `fifo_ren` = 1, decoded from the state. Always go to LOAD.
- **LOAD:** one cycle. `fifo_rdata` is now the head byte, because the FIFO registered it at the FETCH edge.
  - Latch it into the shift register.
  - Compute parity (when enabled).
  - Drive `tx` = 0.
  - Go to START.
- **START:** hold `tx` = 0 for `CLKS_PER_BIT` cycles in total (counted from the LOAD edge), then go to DATA.
- **DATA:** 8 bits, LSB first, each held `CLKS_PER_BIT` cycles. The bit index runs 0..7. After bit 7, go to PARITY if enabled, otherwise to STOP.
- **PARITY:** `tx` = XOR of the 8 data bits (even parity) for `CLKS_PER_BIT` cycles, then go to STOP.
- **STOP:** `tx` = 1 for `CLKS_PER_BIT` cycles. `tx_done` = 1 in the final cycle. Then go to IDLE.
- **Baud counter:** counts 0..`CLKS_PER_BIT`-1 and wraps to 0 when it advances the bit. It is cleared on entry to START.
- **Read pulses:** exactly one `fifo_ren` per frame, never issued when `fifo_count` == 0. The block never reads an empty FIFO.
- **Simultaneous FIFO write in IDLE:** only `fifo_count` is used. A byte written on the same edge that `count` becomes 1 is safe to fetch, because FETCH is at least one edge later.
- **`en` deasserted mid-frame:** no effect until IDLE.
- **Reset mid-frame:** `tx` returns to 1 and `fifo_ren` to 0 immediately (asynchronous). The byte in flight is discarded and is not re-read.
- **`fifo_count` at its maximum (`MAX_DATA`):** no special handling; this block only decrements occupancy.

## Timing
- **Start latency:** IDLE with the condition true in cycle t gives FETCH in t+1, LOAD in t+2, and `tx` falling at the edge ending t+2.
- **Frame length:** the `tx` low-to-stop-end span is 10·`CLKS_PER_BIT` cycles, or 11·`CLKS_PER_BIT` with parity.
- **Back-to-back frames:** minimum spacing from one `tx_done` to the next start-bit edge is 3 cycles (IDLE, FETCH, LOAD), so the frame period is 10·`CLKS_PER_BIT`+3 cycles.
- **FIFO decrement:** `fifo_count` drops by 1 at the FETCH edge (FIFO side). IDLE in the next frame sees the updated value.
- **Outputs:** `tx` is registered. `fifo_ren`, `busy` and `tx_done` are state decodes, glitch-free relative to `clk`.

## Configuration
- `FIFO_UART_TX_PARITY_EN` defined: the PARITY state is compiled in and frames carry an even-parity bit (11 bits).
- Undefined: there is no PARITY state, DATA goes straight to STOP, and frames are 10 bits. Ports are identical in both builds.

## Test plan
- **Reset:** hold `rst`=0 for 5 cycles -> `tx`=1, `busy`=0, `fifo_ren`=0, `tx_done`=0 throughout and after release with `fifo_count`=0.
- **Single byte:** `CLKS_PER_BIT`=4, FIFO holds 0xA5, `en`=1.
  - One `fifo_ren` pulse.
  - `tx` = 0, 1,0,1,0,0,1,0,1, 1, each held 4 cycles.
  - `tx_done` pulse at cycle 40 after the falling edge.
  - With parity: bit 0 inserted before stop, frame is 44 cycles.
- **Back-to-back:** FIFO preloaded with 0x00, 0xFF, 0x3C -> three frames with 3-cycle gaps, exactly 3 `fifo_ren` pulses, and `fifo_count` goes 3->0.
- **`en` gating:** `fifo_count`=2 with `en`=0 for 50 cycles -> no `fifo_ren`, `tx`=1. Dropping `en` mid-frame -> the frame completes and no new FETCH starts.
- **Reset mid-DATA:** `rst` low during bit 4 -> `tx`=1 asynchronously. After release, no frame starts until `fifo_count` != 0.
- **Write to an empty FIFO:** write 0x5A while the block is idle -> the frame starts 3 cycles after `count` reads 1 and carries 0x5A, not stale data.
